// File: rtl/i2s_audio_tx.sv
// i2s_audio_tx: buffers 16-bit mono PCM samples in a small FIFO and serializes each one
// as a Philips I2S frame (same sample on left and right slots) for an external DAC.
// Reports samples dropped on a full FIFO and frames that start with the FIFO empty.
module i2s_audio_tx #(
   parameter int unsigned BCLK_HALF_DIV = 4,
   parameter int unsigned FIFO_DEPTH    = 8
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [15:0]                   sample_in,
   input  logic                          sample_valid,
   output logic                          sample_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          overflow,
   output logic                          underrun,
   output logic                          i2s_bclk,
   output logic                          i2s_lrclk,
   output logic                          i2s_sdata
);

   localparam int unsigned DivW = $clog2(BCLK_HALF_DIV);
   localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
   localparam int unsigned LvlW = PtrW + 1;

   logic [DivW-1:0] div_q, div_d;
   logic            bclk_q, bclk_d;
   logic [4:0]      b_q, b_next;
   logic            lrclk_q, lrclk_d;
   logic            sdata_q, sdata_d;
   logic [31:0]     shift_q, shift_d;
   logic            ovf_q, und_q;

   logic [15:0]     mem [FIFO_DEPTH];
   logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
   logic [LvlW-1:0] level_q, level_d;

   logic            div_term, fall_ev, frame_load;
   logic            fifo_empty, fifo_full, push, pop;

   // Bit-clock timing, bit index and FIFO handshake decode.
   always_comb begin
      div_term   = (div_q == DivW'(BCLK_HALF_DIV - 1));
      div_d      = div_term ? '0 : div_q + 1'b1;
      bclk_d     = div_term ? ~bclk_q : bclk_q;
      // A toggle while BCLK is high is the falling-edge event.
      fall_ev    = div_term & bclk_q;
      // Natural 5-bit wrap gives 31 -> 0.
      b_next     = b_q + 5'd1;
      frame_load = fall_ev & (b_next == 5'd0);
      fifo_empty = (level_q == '0);
      fifo_full  = (level_q == LvlW'(FIFO_DEPTH));
      push       = sample_valid & ~fifo_full;
      pop        = frame_load & ~fifo_empty;
      level_d    = level_q + {{(LvlW-1){1'b0}}, push} - {{(LvlW-1){1'b0}}, pop};
   end

   // Next-state for the serializer: load at frame start, otherwise shift on falling edges.
   always_comb begin
      shift_d = shift_q;
      lrclk_d = lrclk_q;
      sdata_d = sdata_q;
      if (frame_load) begin
         shift_d = fifo_empty ? 32'd0 : {mem[rd_ptr_q], mem[rd_ptr_q]};
      end else if (fall_ev) begin
         shift_d = {shift_q[30:0], 1'b0};
      end
      if (fall_ev) begin
         // LRCLK switches one BCLK before each word's MSB.
         lrclk_d = (b_next >= 5'd15) && (b_next <= 5'd30);
         sdata_d = shift_d[31];
      end
   end

   // Serializer, bit clock and status-pulse registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_q   <= '0;
         bclk_q  <= 1'b0;
         b_q     <= 5'd31;
         lrclk_q <= 1'b0;
         sdata_q <= 1'b0;
         shift_q <= '0;
         ovf_q   <= 1'b0;
         und_q   <= 1'b0;
      end else begin
         div_q   <= div_d;
         bclk_q  <= bclk_d;
         if (fall_ev) begin
            b_q <= b_next;
         end
         lrclk_q <= lrclk_d;
         sdata_q <= sdata_d;
         shift_q <= shift_d;
         ovf_q   <= sample_valid & fifo_full;
         und_q   <= frame_load & fifo_empty;
      end
   end

   // FIFO pointers and occupancy; a full FIFO refuses pushes even when popping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         level_q <= level_d;
      end
   end

   // FIFO storage; contents need no reset since occupancy gates every read.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_q] <= sample_in;
      end
   end

   assign sample_ready = ~fifo_full;
   assign fifo_level   = level_q;
   assign overflow     = ovf_q;
   assign underrun     = und_q;
   assign i2s_bclk     = bclk_q;
   assign i2s_lrclk    = lrclk_q;
   assign i2s_sdata    = sdata_q;

endmodule

// File: tb/tb_i2s_audio_tx.sv
// tb_i2s_audio_tx: scoreboard bench for i2s_audio_tx. A frame-level reference model tracks
// FIFO contents and frame timing from cycle counts; a monitor rebuilds each 32-bit frame
// from BCLK rising edges and compares it with the expected sample popped from a queue.
module tb_i2s_audio_tx;

   localparam int unsigned H = 4;
   localparam int unsigned D = 8;
   localparam int unsigned F = 64 * H;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] sample_in = '0;
   logic        sample_valid = 1'b0;
   logic        sample_ready;
   logic [3:0]  fifo_level;
   logic        overflow, underrun, i2s_bclk, i2s_lrclk, i2s_sdata;

   i2s_audio_tx #(
      .BCLK_HALF_DIV(H),
      .FIFO_DEPTH   (D)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .sample_in   (sample_in),
      .sample_valid(sample_valid),
      .sample_ready(sample_ready),
      .fifo_level  (fifo_level),
      .overflow    (overflow),
      .underrun    (underrun),
      .i2s_bclk    (i2s_bclk),
      .i2s_lrclk   (i2s_lrclk),
      .i2s_sdata   (i2s_sdata)
   );

   always #5 clk = ~clk;

   int          n;            // posedges since reset release
   logic [15:0] mdl_q[$];     // model FIFO contents
   logic [15:0] frame_q[$];   // expected sample per frame (0 for underrun)
   bit          exp_ovf, exp_und;
   int unsigned tests, fails, frames;
   logic [31:0] cap;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (n=%0d)", name, act, exp, n);
      end
   endtask

   // Reference model: frames start every F clks at offset 2H after release; pop before push.
   always @(posedge clk) begin
      int lvl;
      bit load;
      if (!rst_n) begin
         n = 0;
         mdl_q.delete();
         frame_q.delete();
         exp_ovf = 0;
         exp_und = 0;
      end else begin
         n++;
         load = ((n % F) == 2 * H);
         lvl = mdl_q.size();
         exp_ovf = sample_valid && (lvl == D);
         exp_und = load && (lvl == 0);
         if (load) begin
            if (lvl > 0) frame_q.push_back(mdl_q.pop_front());
            else frame_q.push_back(16'h0000);
         end
         if (sample_valid && (lvl < D)) mdl_q.push_back(sample_in);
      end
   end

   // Monitor: checks status every clk and assembles frames on BCLK rises.
   always @(posedge clk) begin
      int m, b;
      logic [15:0] e;
      #1;
      if (!rst_n) begin
         chk("rst_bclk", i2s_bclk, 0);
         chk("rst_lrclk", i2s_lrclk, 0);
         chk("rst_sdata", i2s_sdata, 0);
         chk("rst_level", fifo_level, 0);
         chk("rst_ready", sample_ready, 1);
         chk("rst_ovf", overflow, 0);
         chk("rst_und", underrun, 0);
         cap = '0;
      end else begin
         chk("fifo_level", fifo_level, 32'(mdl_q.size()));
         chk("sample_ready", sample_ready, mdl_q.size() != D);
         chk("overflow", overflow, exp_ovf);
         chk("underrun", underrun, exp_und);
         chk("bclk", i2s_bclk, (n / H) % 2);
         m = n / (2 * H);
         b = (m > 0) ? (m - 1) % 32 : 31;
         chk("lrclk", i2s_lrclk, (m > 0) && (b >= 15) && (b <= 30));
         if ((m > 0) && ((n % (2 * H)) == H)) begin
            cap[31 - b] = i2s_sdata;
            if (b == 31) begin
               frames++;
               if (frame_q.size() == 0) begin
                  tests++;
                  fails++;
                  $display("FAIL frame_word: got %h expected no frame", cap);
               end else begin
                  e = frame_q.pop_front();
                  chk("frame_word", cap, {e, e});
               end
            end
         end
      end
   end

   task automatic drive(input bit v, input logic [15:0] d);
      @(negedge clk);
      sample_valid = v;
      sample_in = d;
   endtask

   // Returns on the negedge where n == ph, with sample_valid low.
   task automatic wait_phase(input int ph);
      do begin
         @(negedge clk);
         sample_valid = 1'b0;
      end while ((n % F) != ph);
   endtask

   task automatic drain();
      for (int i = 0; i < 30 * F && mdl_q.size() != 0; i++) drive(0, '0);
      repeat (F) drive(0, '0);
      chk("drain_level", fifo_level, 0);
   endtask

   initial begin
      rst_n = 1'b0;
      repeat (20) @(negedge clk);
      rst_n = 1'b1;

      // Single sample into an empty FIFO, then idle (underrun) frames.
      drive(1, 16'h8001);
      drive(0, '0);
      repeat (5 * F) drive(0, '0);

      // Nine back-to-back samples between frame loads: ninth is dropped.
      wait_phase(2 * H + 1);
      for (int i = 1; i <= 9; i++) drive(1, 16'(i));
      drive(0, '0);
      repeat (10 * F) drive(0, '0);

      // Full FIFO with push coincident with a pop: push refused.
      wait_phase(2 * H + 1);
      for (int i = 0; i < 8; i++) drive(1, 16'hA000 + 16'(i));
      wait_phase(2 * H - 1);
      sample_valid = 1'b1;
      sample_in = 16'hDEAD;
      drive(0, '0);
      drain();

      // Level 1 with push coincident with a pop: both kept in order.
      wait_phase(2 * H + 1);
      drive(1, 16'h0BEE);
      wait_phase(2 * H - 1);
      sample_valid = 1'b1;
      sample_in = 16'hCAFE;
      drive(0, '0);
      repeat (3 * F) drive(0, '0);

      // Random traffic, first faster than the frame rate, then slower.
      repeat (20 * F) drive($urandom_range(0, 179) == 0, 16'($urandom));
      repeat (10 * F) drive($urandom_range(0, 399) == 0, 16'($urandom));
      drain();

      // Asynchronous reset mid-word (b=20, BCLK high, LRCLK high) with samples queued.
      wait_phase(2 * H + 1);
      drive(1, 16'h1234);
      drive(1, 16'h5678);
      wait_phase(173);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_bclk", i2s_bclk, 0);
      chk("async_lrclk", i2s_lrclk, 0);
      chk("async_sdata", i2s_sdata, 0);
      chk("async_level", fifo_level, 0);
      chk("async_ready", sample_ready, 1);
      repeat (5) @(negedge clk);
      rst_n = 1'b1;
      repeat (3 * F) drive(0, '0);

      chk("frames_seen", frames >= 40, 1);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
